// File: rtl/mips_pkg.sv
// Shared types and constants for the memory arbiter slice.
// State encoding, grant ids, abort data and default sizes.
package mips_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-cycle watchdog counter for the memory arbiter.
// Clears on BUSY entry, saturates once it reaches TIMEOUT.
module mem_arb_timer
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT));

    // Count stalled BUSY cycles; hold at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: fetch and data ports onto one memory port.
// Optional BUSY timeout abort enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    state_t state;
    grant_t last_grant;

    logic              start;
    logic              pick_d;
    logic              expire;
    logic              done;
    logic [DATA_W-1:0] rsp_data;

    assign start  = (state == IDLE) && (if_req || d_req);
    assign pick_d = d_req && (!if_req || last_grant == GNT_IF);
    assign done   = (state == BUSY) && (mem_ready || expire);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);

    logic t_exp;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clr     (start),
        .inc     ((state == BUSY) && !mem_ready),
        .expired (t_exp)
    );

    assign expire   = (state == BUSY) && t_exp && !mem_ready;
    assign rsp_data = mem_ready ? mem_rdata : ERR_RDATA;

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (expire) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT != 0) ^ (^ERR_DATA);
    assign expire     = 1'b0;
    assign rsp_data   = mem_rdata;
    assign err        = 1'b0;
`endif

    // Grant, hold the memory request, then pulse one ack.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GNT_IF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= BUSY;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        if (pick_d) begin
                            last_grant <= GNT_D;
                            mem_we     <= d_we;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                        end else begin
                            last_grant <= GNT_IF;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (done) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (last_grant == GNT_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= (mem_we && mem_ready) ? '0 : rsp_data;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= rsp_data;
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    if_ack   <= 1'b0;
                    d_ack    <= 1'b0;
                    if_rdata <= '0;
                    d_rdata  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vectors, corner sequences,
// and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam int P_IDLE = 0;
    localparam int P_BUSY = 1;
    localparam int P_RESP = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        string       nm;
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] mdata;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        if_req    = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        if_req = !v.is_d;
        d_req  = v.is_d;
        d_we   = v.we;
        if (v.is_d) begin
            d_addr  = v.addr;
            d_wdata = v.wdata;
            if_addr = ~v.addr;
        end else begin
            if_addr = v.addr;
            d_addr  = ~v.addr;
            d_wdata = v.wdata;
        end
        mem_ready = 1'b0;
        for (int c = 1; c <= v.lat + 1; c++) begin
            step();
            chk($sformatf("%s mem_req c%0d", v.nm, c), mem_req, 1);
            chk($sformatf("%s busy c%0d", v.nm, c), busy, 1);
            chk($sformatf("%s mem_addr c%0d", v.nm, c), mem_addr, v.e_addr);
            chk($sformatf("%s mem_we c%0d", v.nm, c), mem_we, v.e_we);
            chk($sformatf("%s mem_wdata c%0d", v.nm, c), mem_wdata, v.e_wdata);
            chk($sformatf("%s early ack c%0d", v.nm, c), {if_ack, d_ack}, 0);
            mem_ready = (c == v.lat + 1);
            mem_rdata = mem_ready ? v.mdata : $urandom;
        end
        step();
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        chk({v.nm, " resp mem_req"}, mem_req, 0);
        chk({v.nm, " if_ack"}, if_ack, !v.is_d);
        chk({v.nm, " d_ack"}, d_ack, v.is_d);
        chk({v.nm, " rdata"}, v.is_d ? d_rdata : if_rdata, v.e_rdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        chk({v.nm, " idle mem_req"}, mem_req, 0);
        chk({v.nm, " idle busy"}, busy, 0);
        chk({v.nm, " idle acks"}, {if_ack, d_ack}, 0);
        step();
        chk({v.nm, " stray ready"}, {mem_req, busy, if_ack, d_ack}, 0);
        mem_ready = 1'b0;
    endtask

    logic          ifp, dp, dwe, last_d, win_d, w_we;
    logic [31:0]   ia, da, dwd, w_addr, w_wd, rsp;
    int            phase, nphase, cnt;

    initial begin
        vecs[0] = '{"fetch40", 1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 2,
                    32'h2402_000A, 1'b0, 32'h40, 32'h0, 32'h2402_000A};
        vecs[1] = '{"dwrite100", 1'b1, 1'b1, 32'h100, 32'h55, 1,
                    32'h1234_5678, 1'b1, 32'h100, 32'h55, 32'h0};
        vecs[2] = '{"dread_min", 1'b1, 1'b0, 32'h2000, 32'hABCD, 0,
                    32'hCAFE_F00D, 1'b0, 32'h2000, 32'hABCD, 32'hCAFE_F00D};
        vecs[3] = '{"fetch_top", 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4,
                    32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0};
        vecs[4] = '{"dwrite_min", 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 0,
                    32'hFFFF_FFFF, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0};

        #3;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst acks", {if_ack, d_ack}, 0);
        chk("rst rdata", {if_rdata, d_rdata}, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        step();
        chk("tie1 addr", mem_addr, 32'h300);
        mem_ready = 1'b1; mem_rdata = 32'h11;
        step();
        mem_ready = 1'b0;
        chk("tie1 d_ack", {if_ack, d_ack}, 2'b01);
        chk("tie1 d_rdata", d_rdata, 32'h11);
        d_req = 1'b0;
        step();
        chk("tie1 idle", mem_req, 0);
        step();
        chk("tie1 fetch req", mem_req, 1);
        chk("tie1 fetch addr", mem_addr, 32'h80);
        mem_ready = 1'b1; mem_rdata = 32'h22;
        step();
        mem_ready = 1'b0;
        chk("tie1 if_ack", {if_ack, d_ack}, 2'b10);
        chk("tie1 if_rdata", if_rdata, 32'h22);
        if_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h84;
        d_req = 1'b1; d_addr = 32'h304;
        step();
        chk("tie2 data wins", mem_addr, 32'h304);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("tie2 d_ack", {if_ack, d_ack}, 2'b01);
        d_req = 1'b0;
        step();
        step();
        chk("tie2 fetch addr", mem_addr, 32'h84);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("tie2 if_ack", {if_ack, d_ack}, 2'b10);
        if_req = 1'b0;
        step();

        if_req = 1'b1; if_addr = 32'h500;
        step();
        step();
        chk("midrst busy before", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst mem_req", mem_req, 0);
        chk("midrst busy", busy, 0);
        chk("midrst acks", {if_ack, d_ack}, 0);
        chk("midrst mem_addr", mem_addr, 0);
        if_req = 1'b0;
        step();
        reset = 1'b1;
        mem_ready = 1'b1;
        step();
        step();
        chk("midrst no ack", {if_ack, d_ack, mem_req}, 0);
        mem_ready = 1'b0;
        run_vec(vecs[0]);

`ifdef MEM_ARB_TIMEOUT_EN
        if_req = 1'b1; if_addr = 32'h600;
        for (int c = 1; c <= TO + 1; c++) begin
            step();
            chk($sformatf("to mem_req c%0d", c), {mem_req, if_ack}, 2'b10);
        end
        step();
        chk("to if_ack", if_ack, 1);
        chk("to rdata", if_rdata, 32'hDEAD_BEEF);
        chk("to mem_req drop", mem_req, 0);
        chk("to err", err, 1);
        if_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("to err sticky", err, 1);
        end
        do_reset();
        #1;
        chk("to err cleared", err, 0);
`else
        if_req = 1'b1; if_addr = 32'h600;
        for (int c = 1; c <= 100; c++) begin
            step();
            chk($sformatf("wait mem_req c%0d", c), {mem_req, err}, 2'b10);
        end
        mem_ready = 1'b1; mem_rdata = 32'h77;
        step();
        mem_ready = 1'b0;
        chk("wait if_ack", if_ack, 1);
        chk("wait rdata", if_rdata, 32'h77);
        if_req = 1'b0;
        step();
`endif

        do_reset();
        ifp = 0; dp = 0; dwe = 0; last_d = 0; win_d = 0;
        ia = 0; da = 0; dwd = 0; w_addr = 0; w_we = 0; w_wd = 0;
        rsp = 0; cnt = 0; phase = P_IDLE;
        for (int k = 0; k < 1500; k++) begin
            if (!ifp && $urandom_range(2) == 0) begin
                ifp = 1'b1;
                ia  = $urandom;
            end
            if (!dp && $urandom_range(2) == 0) begin
                dp  = 1'b1;
                dwe = 1'($urandom_range(1));
                da  = $urandom;
                dwd = $urandom;
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            nphase = phase;
            case (phase)
                P_IDLE: begin
                    if ($urandom_range(3) == 0) mem_ready = 1'b1;
                    if (ifp || dp) begin
                        if (ifp && dp) win_d = !last_d;
                        else win_d = dp;
                        last_d = win_d;
                        w_addr = win_d ? da : ia;
                        w_we   = win_d ? dwe : 1'b0;
                        w_wd   = win_d ? dwd : 32'h0;
                        cnt    = $urandom_range(4);
                        nphase = P_BUSY;
                    end
                end
                P_BUSY: begin
                    if (cnt == 0) begin
                        mem_ready = 1'b1;
                        rsp = (win_d && w_we) ? 32'h0 : mem_rdata;
                        nphase = P_RESP;
                    end else begin
                        cnt--;
                    end
                end
                default: begin
                    if ($urandom_range(1) == 1) mem_ready = 1'b1;
                    if (win_d) dp = 1'b0;
                    else ifp = 1'b0;
                    nphase = P_IDLE;
                end
            endcase
            if_req = ifp; if_addr = ia;
            d_req = dp; d_we = dwe; d_addr = da; d_wdata = dwd;
            step();
            phase = nphase;
            chk($sformatf("rnd%0d err", k), err, 0);
            case (phase)
                P_IDLE: begin
                    chk($sformatf("rnd%0d idle", k),
                        {mem_req, busy, if_ack, d_ack}, 0);
                end
                P_BUSY: begin
                    chk($sformatf("rnd%0d busy", k),
                        {mem_req, busy, if_ack, d_ack}, 4'b1100);
                    chk($sformatf("rnd%0d addr", k), mem_addr, w_addr);
                    chk($sformatf("rnd%0d we", k), mem_we, w_we);
                    chk($sformatf("rnd%0d wdata", k), mem_wdata, w_wd);
                end
                default: begin
                    chk($sformatf("rnd%0d resp", k),
                        {mem_req, busy, if_ack, d_ack},
                        {2'b01, !win_d, win_d});
                    chk($sformatf("rnd%0d rdata", k),
                        win_d ? d_rdata : if_rdata, rsp);
                end
            endcase
        end
        quiet();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
